// File: rtl/sasa_cam.sv
// rtl/sasa_cam.sv - SASA score CAM with streamed load, 1-cycle search and invalidation
module sasa_cam #(
    parameter int CAM_LEN = 16,
    parameter int DATA_W  = 8,
    parameter int PTR_W   = $clog2(CAM_LEN),
    parameter int CNT_W   = $clog2(CAM_LEN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic                load_valid,
    input  logic [DATA_W-1:0]   load_data,
    output logic                load_done,
    input  logic                search_en,
    input  logic [1:0]          search_op,
    input  logic [DATA_W-1:0]   search_key,
    input  logic [DATA_W-1:0]   search_mask,
    output logic [CAM_LEN-1:0]  MatchVector,
    output logic                match_valid,
    output logic                match_any,
    output logic [CNT_W-1:0]    match_cnt,
    input  logic                inval_en,
    input  logic [CAM_LEN-1:0]  inval_vec
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [CAM_LEN-1:0]       valid_q, valid_d;
    logic [DATA_W-1:0]        entry_q [CAM_LEN];
    logic [DATA_W-1:0]        entry_d [CAM_LEN];
    logic [CAM_LEN-1:0]       match_vec_q, match_vec_d;
    logic                     match_valid_q, match_valid_d;
    logic                     match_any_q, match_any_d;
    logic [CNT_W-1:0]         match_cnt_q, match_cnt_d;
    logic                     load_beat;

    // A beat is only accepted while loading, and a same-cycle restart drops it
    assign load_beat = (state_q == ST_LOAD) && load_valid && !load_start;

    // Load FSM, pointer, valid bits and entry writes; restart beats invalidate, load beats beat invalidate
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        entry_d = entry_q;
        if (inval_en) begin
            valid_d = valid_q & ~inval_vec;
        end
        if (load_start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
            valid_d = '0;
        end else if (load_beat) begin
            entry_d[ptr_q] = load_data;
            valid_d[ptr_q] = 1'b1;
            if (ptr_q == PTR_W'(CAM_LEN - 1)) begin
                state_d = ST_READY;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    // Search compare against pre-update contents, plus popcount of the result
    always_comb begin
        match_vec_d   = '0;
        match_valid_d = search_en;
        match_cnt_d   = '0;
        if (search_en) begin
            for (int i = 0; i < CAM_LEN; i++) begin
                if (valid_q[i]) begin
                    case (search_op)
                        2'b00:   match_vec_d[i] = (entry_q[i] == search_key);
                        2'b01:   match_vec_d[i] = (entry_q[i] >= search_key);
                        2'b10:   match_vec_d[i] = (((entry_q[i] ^ search_key) & search_mask) == '0);
                        default: match_vec_d[i] = 1'b0;
                    endcase
                end
            end
        end
        for (int i = 0; i < CAM_LEN; i++) begin
            match_cnt_d = match_cnt_d + {{(CNT_W-1){1'b0}}, match_vec_d[i]};
        end
        match_any_d = |match_vec_d;
    end

    // Control and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            valid_q       <= '0;
            match_vec_q   <= '0;
            match_valid_q <= 1'b0;
            match_any_q   <= 1'b0;
            match_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            valid_q       <= valid_d;
            match_vec_q   <= match_vec_d;
            match_valid_q <= match_valid_d;
            match_any_q   <= match_any_d;
            match_cnt_q   <= match_cnt_d;
        end
    end

    // Entry storage is deliberately left out of reset; valid bits gate it
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign load_done   = (state_q == ST_READY);
    assign MatchVector = match_vec_q;
    assign match_valid = match_valid_q;
    assign match_any   = match_any_q;
    assign match_cnt   = match_cnt_q;

endmodule

// File: tb/tb_sasa_cam.sv
// tb/tb_sasa_cam.sv - directed self-checking bench for sasa_cam
module tb_sasa_cam;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_done;
    logic        search_en;
    logic [1:0]  search_op;
    logic [7:0]  search_key;
    logic [7:0]  search_mask;
    logic [15:0] MatchVector;
    logic        match_valid;
    logic        match_any;
    logic [4:0]  match_cnt;
    logic        inval_en;
    logic [15:0] inval_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sasa_cam dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_done   (load_done),
        .search_en   (search_en),
        .search_op   (search_op),
        .search_key  (search_key),
        .search_mask (search_mask),
        .MatchVector (MatchVector),
        .match_valid (match_valid),
        .match_any   (match_any),
        .match_cnt   (match_cnt),
        .inval_en    (inval_en),
        .inval_vec   (inval_vec)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic search(input logic [1:0] op, input logic [7:0] key, input logic [7:0] mask);
        search_en   = 1'b1;
        search_op   = op;
        search_key  = key;
        search_mask = mask;
    endtask

    task automatic check_result(input string tag, input logic [15:0] mv, input logic [4:0] cnt);
        check({tag, "_mv"}, 32'(MatchVector), 32'(mv));
        check({tag, "_cnt"}, 32'(match_cnt), 32'(cnt));
        check({tag, "_any"}, 32'(match_any), 32'(mv != 16'h0));
        check({tag, "_valid"}, 32'(match_valid), 32'd1);
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        search_en = 1'b0; search_op = 2'b00; search_key = '0; search_mask = '0;
        inval_en = 1'b0; inval_vec = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_mv", 32'(MatchVector), 32'h0);
        check("rst_valid", 32'(match_valid), 32'h0);
        check("rst_any", 32'(match_any), 32'h0);
        check("rst_cnt", 32'(match_cnt), 32'h0);
        check("rst_done", 32'(load_done), 32'h0);

        // Full load 0x10..0x1F
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1; load_data = 8'h10 + 8'(i);
            if (i == 15) check("done_before_last", 32'(load_done), 32'h0);
            tick();
        end
        load_valid = 1'b0;
        check("done_full", 32'(load_done), 32'h1);

        search(2'b00, 8'h13, 8'h00); tick(); search_en = 1'b0;
        check_result("eq13", 16'h0008, 5'd1);
        tick();
        check("idle_valid", 32'(match_valid), 32'h0);
        check("idle_mv", 32'(MatchVector), 32'h0);

        search(2'b01, 8'h1C, 8'h00); tick(); search_en = 1'b0;
        check_result("ge1C", 16'hF000, 5'd4);
        search(2'b01, 8'h10, 8'h00); tick(); search_en = 1'b0;
        check_result("ge10_all", 16'hFFFF, 5'd16);
        inval_en = 1'b1; inval_vec = 16'h8000; tick(); inval_en = 1'b0;
        search(2'b01, 8'h1C, 8'h00); tick(); search_en = 1'b0;
        check_result("ge1C_inval", 16'h7000, 5'd3);
        check("done_after_inval", 32'(load_done), 32'h1);
        search(2'b11, 8'h1C, 8'hFF); tick(); search_en = 1'b0;
        check("op11_mv", 32'(MatchVector), 32'h0);
        check("op11_valid", 32'(match_valid), 32'h1);

        // Masked searches: all 0x5A except entry 3 = 0x5B
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1; load_data = (i == 3) ? 8'h5B : 8'h5A;
            tick();
        end
        load_valid = 1'b0;
        search(2'b10, 8'h50, 8'hF0); tick(); search_en = 1'b0;
        check_result("mask_F0", 16'hFFFF, 5'd16);
        search(2'b10, 8'h00, 8'h01); tick(); search_en = 1'b0;
        check_result("mask_01", 16'hFFF7, 5'd15);

        // Partial load of 5 beats
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("done_reload", 32'(load_done), 32'h0);
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1; load_data = 8'(i); tick();
        end
        load_valid = 1'b0;
        search(2'b10, 8'h00, 8'h00); tick(); search_en = 1'b0;
        check_result("partial", 16'h001F, 5'd5);
        check("partial_done", 32'(load_done), 32'h0);
        // Restart with a colliding beat: beat dropped, valids cleared
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'hEE; tick();
        load_start = 1'b0; load_valid = 1'b0;
        search(2'b10, 8'h00, 8'h00); tick(); search_en = 1'b0;
        check("restart_mv", 32'(MatchVector), 32'h0);
        check("restart_valid", 32'(match_valid), 32'h1);

        // Hazards: fill entries 0..6 with 0x00, then write entry 7 = 0x99 while searching
        for (int i = 0; i < 7; i++) begin
            load_valid = 1'b1; load_data = 8'h00; tick();
        end
        load_valid = 1'b1; load_data = 8'h99;
        search(2'b00, 8'h99, 8'h00); tick();
        load_valid = 1'b0;
        check("hz_write_same", 32'(MatchVector), 32'h0);
        tick();
        check_result("hz_write_next", 16'h0080, 5'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("b2b_valid%0d", i), 32'(match_valid), 32'h1);
            check($sformatf("b2b_mv%0d", i), 32'(MatchVector), 32'h0080);
        end
        search_en = 1'b0; tick();
        check("b2b_end_valid", 32'(match_valid), 32'h0);
        // Invalidate with same-cycle search sees old valid
        inval_en = 1'b1; inval_vec = 16'h0080;
        search(2'b00, 8'h99, 8'h00); tick();
        inval_en = 1'b0;
        check("hz_inval_same", 32'(MatchVector), 32'h0080);
        tick(); search_en = 1'b0;
        check("hz_inval_next", 32'(MatchVector), 32'h0);
        // Load beat on entry 8 wins over same-cycle invalidate of it
        load_valid = 1'b1; load_data = 8'h99; inval_en = 1'b1; inval_vec = 16'h0100; tick();
        load_valid = 1'b0; inval_en = 1'b0;
        search(2'b00, 8'h99, 8'h00); tick(); search_en = 1'b0;
        check_result("load_beats_inval", 16'h0100, 5'd1);
        // Invalidate together with load_start: valids end cleared
        inval_en = 1'b1; inval_vec = 16'h0001; load_start = 1'b1; tick();
        inval_en = 1'b0; load_start = 1'b0;
        load_valid = 1'b1; load_data = 8'h42; tick(); load_valid = 1'b0;
        search(2'b10, 8'h00, 8'h00); tick(); search_en = 1'b0;
        check_result("start_beats_inval", 16'h0001, 5'd1);

        // Reset during a search
        search(2'b10, 8'h00, 8'h00); reset = 1'b1; tick();
        reset = 1'b0; search_en = 1'b0;
        check("rst_search_valid", 32'(match_valid), 32'h0);
        check("rst_search_mv", 32'(MatchVector), 32'h0);
        check("rst_search_done", 32'(load_done), 32'h0);
        search(2'b10, 8'h00, 8'h00); tick(); search_en = 1'b0;
        check("rst_all_invalid", 32'(MatchVector), 32'h0);
        check("rst_post_valid", 32'(match_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sasa_cam.md
Name: sasa_cam

Overview:
- CAM array that answers SASA search requests: stores CAM_LEN score entries and returns a one-hot-per-entry MatchVector for each presented key.
- Sits between the SASA controller's data4CAM output and its MatchVector input; the MVU consumes the vector downstream.
- Entries are filled by a streamed load (auto-incrementing pointer). Matched entries can be invalidated so iterative FindMax passes exclude prior winners.

Parameters:
- CAM_LEN, 16: number of entries; equals `SASA_CAM_len.
- DATA_W, 8: entry and key width.
- PTR_W, $clog2(CAM_LEN): load pointer width.
- CNT_W, $clog2(CAM_LEN+1): match count width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  clears all valid bits and pointer; enters LOAD.
- load_valid  in  1  load beat qualifier.
- load_data  in  DATA_W  entry data for current beat.
- load_done  out  1  high while state is READY (all CAM_LEN entries written).
- search_en  in  1  search request, one key per cycle.
- search_op  in  2  00 = equal, 01 = entry >= key (unsigned), 10 = masked equal, 11 = reserved (no match).
- search_key  in  DATA_W  key (driven from data4CAM).
- search_mask  in  DATA_W  1 = compare bit; used only for op 10.
- MatchVector  out  CAM_LEN  bit i = entry i valid and matches.
- match_valid  out  1  MatchVector/match_any/match_cnt are valid this cycle.
- match_any  out  1  OR of MatchVector.
- match_cnt  out  CNT_W  popcount of MatchVector.
- inval_en  in  1  clear valid bits selected by inval_vec.
- inval_vec  in  CAM_LEN  entries to invalidate.

Behaviour:
- All of the following are on one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - State IDLE; load pointer 0; all valid bits 0.
  - Entry storage is not reset.
  - MatchVector 0, match_valid 0, match_any 0, match_cnt 0, load_done 0.
- FSM states: IDLE, LOAD, READY.
  - IDLE, load_start=1 -> LOAD (valid bits cleared, pointer 0).
  - LOAD, load_valid=1: entry[ptr] <= load_data; valid[ptr] <= 1; ptr++.
  - LOAD, beat with ptr == CAM_LEN-1 -> READY, ptr wraps to 0.
  - READY, load_start=1 -> LOAD (reload).
  - load_start in any state restarts LOAD. It takes priority over a same-cycle load_valid, and that beat is dropped.
- Searching:
  - Allowed in any state; invalid entries never match.
  - Latency 1: search_en in cycle N -> match outputs and match_valid=1 in cycle N+1.
  - search_en=0 -> next cycle match_valid=0 and MatchVector=0.
  - Back-to-back searches are fully pipelined.
- Compare rules:
  - op 00: entry == key.
  - op 01: unsigned entry >= key.
  - op 10: ((entry ^ key) & mask) == 0; mask 0 matches every valid entry.
  - op 11: all zero, match_valid still 1.
- Same-cycle hazards:
  - A search in the same cycle as a write or invalidate sees pre-update contents and valid bits. The update is visible to searches from the next cycle.
  - inval_en on an entry being loaded in the same cycle: the load wins (valid=1).
  - inval_en with load_start: load_start wins.
- Invalidation is allowed in any state and does not change state or pointer.
- match_cnt saturates naturally; CNT_W holds CAM_LEN.
- Reset mid-load or mid-search:
  - The next cycle shows reset values.
  - A search in flight during reset is discarded (match_valid=0).

Test Plan:
- Reset then load_start plus 16 beats of data 0x10..0x1F -> load_done=1 the cycle after the 16th beat, ptr=0. Search op00 key 0x13 -> next cycle MatchVector=16'h0008, match_cnt=1, match_any=1.
- Loaded as above, op01 key 0x1C -> MatchVector=16'hF000, match_cnt=4. Then inval_en with inval_vec=16'h8000, and next cycle op01 key 0x1C -> MatchVector=16'h7000, cnt=3.
- Masked search: entries all 0x5A except entry 3 = 0x5B, op10 key 0x50 mask 0xF0 -> MatchVector=16'hFFFF. Same with mask 0x01, key 0x00 -> MatchVector=16'hFFF7.
- Partial load: 5 beats then search op10 mask 0 -> MatchVector=16'h001F, load_done=0. A load_start mid-stream drops that cycle's beat and clears valids -> next search gives 16'h0000.
- Hazard: write entry 7 = 0x99 while searching key 0x99 in the same cycle -> no match for bit 7. A search the following cycle -> bit 7 set. Back-to-back search_en for 4 cycles -> match_valid high 4 consecutive cycles with 1-cycle lag.
- Assert reset during a search -> next cycle match_valid=0, MatchVector=0, load_done=0, all entries invalid (op10 mask 0 search returns 0).
